fetch_pc_unit: RTL and testbench

- Dual-issue fetch-stage PC sequencer. It sits directly upstream of the local branch predictor.
- It owns the fetch PC register, drives the PC into the predictor and into instruction memory, and consumes the predictor's nextPC and per-slot decode-flush outputs.
- It loads the IF/ID pipeline registers for slot A (pc) and slot B (pc+4).
- It handles multi-cycle instruction-memory latency, hazard stalls, and wrong-path fetch draining.

---
 rtl/fetch_pc_unit_if.sv | 32 +++
 rtl/fetch_pc_unit.sv | 155 +++++++++++++++
 tb/tb_fetch_pc_unit.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_pc_unit_if.sv
// rtl/fetch_pc_unit_if.sv - instruction-memory fetch bus between fetch_pc_unit and imem
//
// Purpose: groups the request/response signals of the dual-word imem fetch port.
// Signals:
//   imem_req      fetch request valid (driven by the fetch unit)
//   imem_addr     fetch address, word aligned (driven by the fetch unit)
//   imem_ready    imem returns both words this cycle (driven by imem)
//   imem_rdata_a  word at imem_addr (driven by imem)
//   imem_rdata_b  word at imem_addr+4 (driven by imem)
interface fetch_pc_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata_a;
  logic [31:0] imem_rdata_b;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata_a,
    input  imem_rdata_b
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata_a,
    output imem_rdata_b
  );
endinterface

// File: rtl/fetch_pc_unit.sv
// rtl/fetch_pc_unit.sv - dual-issue fetch-stage PC sequencer feeding the IF/ID registers
//
// Purpose: owns the fetch PC, issues dual-word imem fetches, loads IF/ID slot A (pc)
// and slot B (pc+4), handles imem latency (WAIT), hazard stalls and draining of a
// wrong-path request after a predictor flush (DRAIN).
// Ports:
//   CLK, RST            clock (rising edge), asynchronous active-low reset
//   imem                imem fetch bus (master side)
//   pc_f                current fetch PC to the predictor
//   pred_next_pc        predictor nextPC for the following fetch group
//   pred_a_taken        slot A predicted taken -> slot B becomes a NOP
//   a_dflush, b_dflush  predictor flush requests
//   stall_f             hazard stall: hold PC and IF/ID
//   instr_*_d, pc_*_d, valid_*_d   IF/ID slot registers
//   bubble_cnt          saturating count of IF/ID loads with no valid instruction
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic                   CLK,
  input  logic                   RST,
  fetch_pc_unit_if.master        imem,
  output logic [31:0]            pc_f,
  input  logic [31:0]            pred_next_pc,
  input  logic                   pred_a_taken,
  input  logic                   a_dflush,
  input  logic                   b_dflush,
  input  logic                   stall_f,
  output logic [31:0]            instr_a_d,
  output logic [31:0]            instr_b_d,
  output logic [31:0]            pc_a_d,
  output logic [31:0]            pc_b_d,
  output logic                   valid_a_d,
  output logic                   valid_b_d,
  output logic [15:0]            bubble_cnt
);

  typedef enum logic [1:0] {S_FETCH, S_WAIT, S_DRAIN} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] redirect_q, redirect_d;
  logic [31:0] instr_a_q, instr_a_d_n;
  logic [31:0] instr_b_q, instr_b_d_n;
  logic [31:0] pc_a_q, pc_a_d_n;
  logic [31:0] pc_b_q, pc_b_d_n;
  logic        valid_a_q, valid_a_d_n;
  logic        valid_b_q, valid_b_d_n;
  logic [15:0] bubble_q, bubble_d;

  logic        flush;
  logic        req;
  logic        complete;
  logic        load_bubble;
  logic [31:0] next_pc_aligned;

  assign flush           = a_dflush | b_dflush;
  // DRAIN must keep its wrong-path request alive until imem answers, even under stall.
  assign req             = (state_q == S_DRAIN) | ~stall_f;
  assign complete        = req & imem.imem_ready;
  assign next_pc_aligned = {pred_next_pc[31:2], 2'b00};

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    redirect_d  = redirect_q;
    instr_a_d_n = instr_a_q;
    instr_b_d_n = instr_b_q;
    pc_a_d_n    = pc_a_q;
    pc_b_d_n    = pc_b_q;
    valid_a_d_n = valid_a_q;
    valid_b_d_n = valid_b_q;
    load_bubble = 1'b0;

    if (flush) begin
      valid_a_d_n = 1'b0;
      valid_b_d_n = 1'b0;
      instr_a_d_n = NOP_INSTR;
      instr_b_d_n = NOP_INSTR;
      redirect_d  = next_pc_aligned;
      load_bubble = 1'b1;
      // Redirect immediately only if no request is left in flight at imem.
      if (complete || (state_q == S_FETCH && !req)) begin
        pc_d    = next_pc_aligned;
        state_d = S_FETCH;
      end else begin
        state_d = S_DRAIN;
      end
    end else if (state_q == S_DRAIN) begin
      valid_a_d_n = 1'b0;
      valid_b_d_n = 1'b0;
      load_bubble = 1'b1;
      if (imem.imem_ready) begin
        pc_d    = redirect_q;
        state_d = S_FETCH;
      end
    end else if (stall_f) begin
      // hold everything
    end else if (complete) begin
      pc_a_d_n    = pc_q;
      pc_b_d_n    = pc_q + 32'd4;
      instr_a_d_n = imem.imem_rdata_a;
      instr_b_d_n = pred_a_taken ? NOP_INSTR : imem.imem_rdata_b;
      valid_a_d_n = 1'b1;
      valid_b_d_n = ~pred_a_taken;
      pc_d        = next_pc_aligned;
      state_d     = S_FETCH;
    end else begin
      valid_a_d_n = 1'b0;
      valid_b_d_n = 1'b0;
      load_bubble = 1'b1;
      state_d     = S_WAIT;
    end

    bubble_d = (load_bubble && bubble_q != 16'hFFFF) ? bubble_q + 16'd1 : bubble_q;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= S_FETCH;
      pc_q       <= RESET_PC;
      redirect_q <= 32'h0;
      instr_a_q  <= NOP_INSTR;
      instr_b_q  <= NOP_INSTR;
      pc_a_q     <= 32'h0;
      pc_b_q     <= 32'h0;
      valid_a_q  <= 1'b0;
      valid_b_q  <= 1'b0;
      bubble_q   <= 16'h0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      redirect_q <= redirect_d;
      instr_a_q  <= instr_a_d_n;
      instr_b_q  <= instr_b_d_n;
      pc_a_q     <= pc_a_d_n;
      pc_b_q     <= pc_b_d_n;
      valid_a_q  <= valid_a_d_n;
      valid_b_q  <= valid_b_d_n;
      bubble_q   <= bubble_d;
    end
  end

  assign pc_f           = pc_q;
  assign imem.imem_addr = pc_q;
  assign imem.imem_req  = req;
  assign instr_a_d      = instr_a_q;
  assign instr_b_d      = instr_b_q;
  assign pc_a_d         = pc_a_q;
  assign pc_b_d         = pc_b_q;
  assign valid_a_d      = valid_a_q;
  assign valid_b_d      = valid_b_q;
  assign bubble_cnt     = bubble_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb/tb_fetch_pc_unit.sv - scoreboard testbench for fetch_pc_unit
module tb_fetch_pc_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct {
    logic [31:0] pc_a;
    logic [31:0] pc_b;
    logic [31:0] ia;
    logic [31:0] ib;
    logic        vb;
  } exp_t;

  logic        CLK;
  logic        RST;
  logic [31:0] pc_f;
  logic [31:0] pred_next_pc;
  logic        pred_a_taken;
  logic        a_dflush;
  logic        b_dflush;
  logic        stall_f;
  logic [31:0] instr_a_d, instr_b_d, pc_a_d, pc_b_d;
  logic        valid_a_d, valid_b_d;
  logic [15:0] bubble_cnt;

  int checks;
  int failures;
  exp_t sb[$];
  logic held;

  fetch_pc_unit_if imem_bus ();

  fetch_pc_unit #(.RESET_PC(32'h0), .NOP_INSTR(NOP)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .imem         (imem_bus.master),
    .pc_f         (pc_f),
    .pred_next_pc (pred_next_pc),
    .pred_a_taken (pred_a_taken),
    .a_dflush     (a_dflush),
    .b_dflush     (b_dflush),
    .stall_f      (stall_f),
    .instr_a_d    (instr_a_d),
    .instr_b_d    (instr_b_d),
    .pc_a_d       (pc_a_d),
    .pc_b_d       (pc_b_d),
    .valid_a_d    (valid_a_d),
    .valid_b_d    (valid_b_d),
    .bubble_cnt   (bubble_cnt)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  assign imem_bus.imem_rdata_a = mem_word(imem_bus.imem_addr);
  assign imem_bus.imem_rdata_b = mem_word(imem_bus.imem_addr + 32'd4);

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Edges where IF/ID was held by a stall do not present a new group.
  always @(posedge CLK) held <= stall_f & ~(a_dflush | b_dflush);

  always @(negedge CLK) begin
    if (RST && valid_a_d && !held) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_load: got pc_a %h expected none", pc_a_d);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("mon_pc_a", pc_a_d, e.pc_a);
        chk("mon_pc_b", pc_b_d, e.pc_b);
        chk("mon_instr_a", instr_a_d, e.ia);
        chk("mon_instr_b", instr_b_d, e.ib);
        chk("mon_valid_b", {31'b0, valid_b_d}, {31'b0, e.vb});
      end
    end
  end

  task automatic drive(input logic rdy, input logic [31:0] nxt, input logic tk,
                       input logic af, input logic bf, input logic st);
    imem_bus.imem_ready = rdy;
    pred_next_pc        = nxt;
    pred_a_taken        = tk;
    a_dflush            = af;
    b_dflush            = bf;
    stall_f             = st;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic expect_load(input logic [31:0] pc, input logic tk);
    exp_t e;
    e.pc_a = pc;
    e.pc_b = pc + 32'd4;
    e.ia   = mem_word(pc);
    e.ib   = tk ? NOP : mem_word(pc + 32'd4);
    e.vb   = ~tk;
    sb.push_back(e);
  endtask

  task automatic fetch(input logic [31:0] pc, input logic [31:0] nxt, input logic tk);
    drive(1'b1, nxt, tk, 1'b0, 1'b0, 1'b0);
    expect_load(pc, tk);
    tick();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    RST      = 1'b0;
    drive(1'b1, 32'h8, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_pc_f", pc_f, 32'h0);
    chk("rst_valid_a", {31'b0, valid_a_d}, 32'h0);
    chk("rst_instr_a", instr_a_d, NOP);
    chk("rst_bubble", {16'b0, bubble_cnt}, 32'h0);
    RST = 1'b1;
    #1;
    chk("rst_req", {31'b0, imem_bus.imem_req}, 32'h1);
    chk("imem_addr", imem_bus.imem_addr, 32'h0);

    // streaming at full rate
    fetch(32'h0, 32'h8, 1'b0);
    chk("pc_f_8", pc_f, 32'h8);
    fetch(32'h8, 32'h10, 1'b0);
    fetch(32'h10, 32'h20, 1'b0);
    chk("pc_f_20", pc_f, 32'h20);
    // slot A predicted taken
    fetch(32'h20, 32'h100, 1'b1);
    chk("pc_f_100", pc_f, 32'h100);
    chk("taken_instr_b", instr_b_d, NOP);
    fetch(32'h100, 32'h40, 1'b0);
    chk("bubble_0", {16'b0, bubble_cnt}, 32'h0);

    // 3-cycle imem miss
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 32'h48, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
    end
    chk("miss_pc_hold", pc_f, 32'h40);
    chk("miss_bubble", {16'b0, bubble_cnt}, 32'h3);
    chk("miss_valid_a", {31'b0, valid_a_d}, 32'h0);
    fetch(32'h40, 32'h48, 1'b0);
    chk("pc_f_48", pc_f, 32'h48);

    // flush during WAIT -> DRAIN -> 0x200
    drive(1'b0, 32'h50, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b0, 32'h200, 1'b0, 1'b1, 1'b0, 1'b0); tick();
    chk("drain_pc_hold", pc_f, 32'h48);
    drive(1'b0, 32'h999, 1'b0, 1'b0, 1'b0, 1'b1);
    #1;
    chk("drain_req_stall", {31'b0, imem_bus.imem_req}, 32'h1);
    tick();
    drive(1'b1, 32'h999, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    chk("drain_redirect", pc_f, 32'h200);
    chk("drain_discard", {31'b0, valid_a_d}, 32'h0);
    chk("drain_bubble", {16'b0, bubble_cnt}, 32'h7);

    // second flush inside DRAIN overrides the redirect target
    drive(1'b0, 32'h208, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b0, 32'h200, 1'b0, 1'b1, 1'b0, 1'b0); tick();
    drive(1'b0, 32'h301, 1'b0, 1'b0, 1'b1, 1'b0); tick();
    drive(1'b1, 32'h999, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    chk("drain2_redirect", pc_f, 32'h300);

    // stall hold then stall+flush
    fetch(32'h300, 32'h308, 1'b0);
    drive(1'b1, 32'h500, 1'b0, 1'b0, 1'b0, 1'b1);
    #1;
    chk("stall_req", {31'b0, imem_bus.imem_req}, 32'h0);
    tick();
    chk("stall_pc_hold", pc_f, 32'h308);
    chk("stall_valid_hold", {31'b0, valid_a_d}, 32'h1);
    chk("stall_pc_a_hold", pc_a_d, 32'h300);
    drive(1'b1, 32'h400, 1'b0, 1'b0, 1'b1, 1'b1); tick();
    chk("stallflush_pc", pc_f, 32'h400);
    chk("stallflush_valid_b", {31'b0, valid_b_d}, 32'h0);
    chk("stallflush_bubble", {16'b0, bubble_cnt}, 32'hC);

    // pc+4 wrap and nextPC low-bit masking
    fetch(32'h400, 32'hFFFF_FFFC, 1'b0);
    fetch(32'hFFFF_FFFC, 32'h0000_0001, 1'b0);
    chk("wrap_pc_b", pc_b_d, 32'h0);
    chk("mask_pc_f", pc_f, 32'h0);

    // asynchronous reset in the middle of DRAIN
    drive(1'b0, 32'h8, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b0, 32'h600, 1'b0, 1'b1, 1'b0, 1'b0); tick();
    drive(1'b0, 32'h8, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    RST = 1'b0;
    #1;
    chk("arst_pc_f", pc_f, 32'h0);
    chk("arst_bubble", {16'b0, bubble_cnt}, 32'h0);
    chk("arst_instr_b", instr_b_d, NOP);
    @(posedge CLK);
    #1;
    RST = 1'b1;
    fetch(32'h0, 32'h8, 1'b0);
    chk("arst_fetch_pc", pc_f, 32'h8);

    // bubble counter saturation
    drive(1'b0, 32'h10, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 65535; i++) tick();
    chk("sat_reach", {16'b0, bubble_cnt}, 32'hFFFF);
    repeat (3) tick();
    chk("sat_hold", {16'b0, bubble_cnt}, 32'hFFFF);

    chk("sb_empty", sb.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
